// File: rtl/port_slicer_bank.sv
// Slices N_FIELDS fixed-position fields out of a packed bus into extended output lanes.
// SYNC_MODE selects plain registered pass-through or a load/apply double buffer.
module port_slicer_bank #(
   parameter int DIN_WIDTH    = 512,
   parameter int N_FIELDS     = 8,
   parameter int FIELD_WIDTH  = 32,
   parameter int FIELD_BASE   = 0,
   parameter int FIELD_STRIDE = 32,
   parameter int OUT_WIDTH    = 32,
   parameter int SIGN_EXT     = 0,
   parameter int SYNC_MODE    = 0
) (
   input  logic                          aclk,
   input  logic                          aresetn,
   input  logic [DIN_WIDTH-1:0]          din,
   input  logic                          load,
   input  logic                          apply,
   output logic [N_FIELDS*OUT_WIDTH-1:0] dout,
   output logic [N_FIELDS-1:0]           changed,
   output logic                          updated,
   output logic                          pending
);

   localparam int LANES_W = N_FIELDS * OUT_WIDTH;
   localparam int TOP_BIT = FIELD_BASE + (N_FIELDS - 1) * FIELD_STRIDE + FIELD_WIDTH;

   if (TOP_BIT > DIN_WIDTH || N_FIELDS < 1 || N_FIELDS > 16 ||
       FIELD_STRIDE < FIELD_WIDTH || OUT_WIDTH < FIELD_WIDTH) begin : g_cfg_err
      $error("port_slicer_bank: field layout does not fit the configured widths");
   end

   typedef enum logic {IDLE, ARMED} state_t;

   function automatic logic [OUT_WIDTH-1:0] extend(input logic [FIELD_WIDTH-1:0] f);
      logic [OUT_WIDTH-1:0] r;
      r = '0;
      r[FIELD_WIDTH-1:0] = f;
      for (int b = FIELD_WIDTH; b < OUT_WIDTH; b++) begin
         r[b] = (SIGN_EXT != 0) ? f[FIELD_WIDTH-1] : 1'b0;
      end
      return r;
   endfunction

   state_t              state_q, state_d;
   logic [LANES_W-1:0]  dout_q, dout_d;
   logic [LANES_W-1:0]  shadow_q, shadow_d;
   logic [N_FIELDS-1:0] changed_q;
   logic                updated_q;
   logic [LANES_W-1:0]  din_ext;
   logic [N_FIELDS-1:0] lane_diff;
   logic                wr;
   logic                din_unused;

   // Bits between or beyond the fields are intentionally dropped.
   assign din_unused = ^din;

   for (genvar i = 0; i < N_FIELDS; i++) begin : g_lane
      assign din_ext[i*OUT_WIDTH +: OUT_WIDTH] =
         extend(din[FIELD_BASE + i*FIELD_STRIDE +: FIELD_WIDTH]);
      assign lane_diff[i] = (dout_d[i*OUT_WIDTH +: OUT_WIDTH] != dout_q[i*OUT_WIDTH +: OUT_WIDTH]);
   end

   always_comb begin
      state_d  = state_q;
      shadow_d = shadow_q;
      dout_d   = dout_q;
      wr       = 1'b0;
      if (SYNC_MODE == 0) begin
         state_d = IDLE;
         dout_d  = din_ext;
         wr      = (din_ext != dout_q);
      end else begin
         case (state_q)
            IDLE: begin
               if (load && apply) begin
                  dout_d   = din_ext;
                  shadow_d = din_ext;
                  wr       = 1'b1;
               end else if (load) begin
                  shadow_d = din_ext;
                  state_d  = ARMED;
               end
            end
            ARMED: begin
               // Simultaneous load+apply bypasses the stale shadow entirely.
               if (load && apply) begin
                  dout_d   = din_ext;
                  shadow_d = din_ext;
                  wr       = 1'b1;
                  state_d  = IDLE;
               end else if (load) begin
                  shadow_d = din_ext;
               end else if (apply) begin
                  dout_d  = shadow_q;
                  wr      = 1'b1;
                  state_d = IDLE;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         state_q   <= IDLE;
         dout_q    <= '0;
         shadow_q  <= '0;
         changed_q <= '0;
         updated_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         dout_q    <= dout_d;
         shadow_q  <= shadow_d;
         changed_q <= wr ? lane_diff : '0;
         updated_q <= wr;
      end
   end

   assign dout    = dout_q;
   assign changed = changed_q;
   assign updated = updated_q;
   assign pending = (state_q == ARMED);

endmodule
